mem_deshuffler_v2: RTL and testbench

MEM_DESHUFFLER_V2 -- requirements
Module: mem_deshuffler_v2

---
 rtl/mem_deshuffler_v2.sv | 151 +++++++++++++++
 tb/tb_mem_deshuffler_v2.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_deshuffler_v2.sv
// mem_deshuffler_v2: reorders lane-ordered VRF beats into memory byte order.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   req_valid_i/req_ready_o            transaction request handshake
//   req_sew_i, req_bytes_i             element width and total byte count
//   vrf_valid_i/vrf_ready_o/vrf_data_i lane-ordered input beat stream
//   mem_valid_o/mem_ready_i            memory-ordered output beat handshake
//   mem_data_o, mem_strb_o, mem_last_o memory-ordered payload, byte strobe, last flag
//   done_o                             one-cycle completion pulse

package mem_deshuffler_v2_pkg;
    typedef enum logic [1:0] {EW8, EW16, EW32, EW64} vew_e;
endpackage

module mem_deshuffler_v2
    import mem_deshuffler_v2_pkg::*;
#(
    parameter int unsigned NrLane   = 4,
    parameter int unsigned VrfWidth = 64,
    parameter int unsigned CntWidth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  vew_e                         req_sew_i,
    input  logic [CntWidth-1:0]          req_bytes_i,
    input  logic                         vrf_valid_i,
    output logic                         vrf_ready_o,
    input  logic [NrLane*VrfWidth-1:0]   vrf_data_i,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic [NrLane*VrfWidth-1:0]   mem_data_o,
    output logic [NrLane*VrfWidth/8-1:0] mem_strb_o,
    output logic                         mem_last_o,
    output logic                         done_o
);

    localparam int unsigned LaneBytes = VrfWidth / 8;
    localparam int unsigned BeatBytes = NrLane * LaneBytes;
    localparam int unsigned DataW     = BeatBytes * 8;
    localparam int unsigned LaneSh    = $clog2(NrLane);
    localparam int unsigned LbSh      = $clog2(LaneBytes);
    localparam int unsigned IdxW      = $clog2(BeatBytes);
    localparam int unsigned BitIdxW   = IdxW + 3;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    state_e                state_q;
    vew_e                  sew_q;
    logic [CntWidth-1:0]   rem_q, rem_d;
    logic                  mem_valid_q, mem_last_q, done_q;
    logic [DataW-1:0]      mem_data_q, mem_data_d;
    logic [BeatBytes-1:0]  mem_strb_q, mem_strb_d;
    logic                  mem_last_d;
    logic                  vrf_hs, mem_hs;

    assign req_ready_o = (state_q == IDLE);
    assign vrf_ready_o = (state_q == ACTIVE) && (!mem_valid_q || mem_ready_i);
    assign vrf_hs      = vrf_valid_i && vrf_ready_o;
    assign mem_hs      = mem_valid_q && mem_ready_i;

    assign mem_valid_o = mem_valid_q;
    assign mem_data_o  = mem_data_q;
    assign mem_strb_o  = mem_strb_q;
    assign mem_last_o  = mem_last_q;
    assign done_o      = done_q;

    // Memory byte i takes element e=i>>sew, byte b; elements are striped across lanes.
    // Lane counts and element widths are powers of two, so div/mod reduce to shifts/masks.
    always_comb begin
        int unsigned sh;
        int unsigned elem;
        int unsigned src;
        logic [IdxW-1:0]    src_idx;
        logic [BitIdxW-1:0] bit_idx;
        sh         = 32'(sew_q);
        elem       = 0;
        src        = 0;
        src_idx    = '0;
        bit_idx    = '0;
        mem_data_d = '0;
        mem_strb_d = '0;
        for (int unsigned i = 0; i < BeatBytes; i++) begin
            elem    = i >> sh;
            src     = ((elem & (NrLane - 1)) << LbSh)
                    + ((elem >> LaneSh) << sh)
                    + (i & ((32'd1 << sh) - 32'd1));
            src_idx = IdxW'(src);
            bit_idx = {src_idx, 3'b000};
            mem_data_d[i*8 +: 8] = vrf_data_i[bit_idx +: 8];
            mem_strb_d[i]        = (32'(rem_q) > i);
        end
    end

    assign mem_last_d = (32'(rem_q) <= BeatBytes);
    assign rem_d      = mem_last_d ? '0 : rem_q - CntWidth'(BeatBytes);

    // Control FSM and output register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sew_q       <= EW8;
            rem_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_data_q  <= '0;
            mem_strb_q  <= '0;
            mem_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mem_hs) begin
                mem_valid_q <= 1'b0;
            end
            // An accept in the same cycle as an output handshake refills with no bubble.
            if (vrf_hs) begin
                mem_valid_q <= 1'b1;
                mem_data_q  <= mem_data_d;
                mem_strb_q  <= mem_strb_d;
                mem_last_q  <= mem_last_d;
                rem_q       <= rem_d;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        sew_q <= req_sew_i;
                        rem_q <= req_bytes_i;
                        if (req_bytes_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (vrf_hs && mem_last_d) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_hs && mem_last_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_deshuffler_v2.sv
// tb_mem_deshuffler_v2: scoreboard bench for mem_deshuffler_v2 at NrLane 4, 1 and 16.
module tb_mem_deshuffler_v2;
    import mem_deshuffler_v2_pkg::*;

    typedef struct {
        logic [1023:0] data;
        logic [127:0]  strb;
        logic          last;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic rv0, rr0, vv0, vr0, mv0, mr0, ml0, dn0;
    vew_e sw0; logic [15:0] rb0; logic [255:0] vd0, md0; logic [31:0] ms0;
    logic rv1, rr1, vv1, vr1, mv1, mr1, ml1, dn1;
    vew_e sw1; logic [15:0] rb1; logic [63:0] vd1, md1; logic [7:0] ms1;
    logic rv2, rr2, vv2, vr2, mv2, mr2, ml2, dn2;
    vew_e sw2; logic [15:0] rb2; logic [1023:0] vd2, md2; logic [127:0] ms2;

    mem_deshuffler_v2 #(.NrLane(4), .VrfWidth(64), .CntWidth(16)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv0), .req_ready_o(rr0), .req_sew_i(sw0),
        .req_bytes_i(rb0), .vrf_valid_i(vv0), .vrf_ready_o(vr0), .vrf_data_i(vd0),
        .mem_valid_o(mv0), .mem_ready_i(mr0), .mem_data_o(md0), .mem_strb_o(ms0),
        .mem_last_o(ml0), .done_o(dn0));
    mem_deshuffler_v2 #(.NrLane(1), .VrfWidth(64), .CntWidth(16)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv1), .req_ready_o(rr1), .req_sew_i(sw1),
        .req_bytes_i(rb1), .vrf_valid_i(vv1), .vrf_ready_o(vr1), .vrf_data_i(vd1),
        .mem_valid_o(mv1), .mem_ready_i(mr1), .mem_data_o(md1), .mem_strb_o(ms1),
        .mem_last_o(ml1), .done_o(dn1));
    mem_deshuffler_v2 #(.NrLane(16), .VrfWidth(64), .CntWidth(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv2), .req_ready_o(rr2), .req_sew_i(sw2),
        .req_bytes_i(rb2), .vrf_valid_i(vv2), .vrf_ready_o(vr2), .vrf_data_i(vd2),
        .mem_valid_o(mv2), .mem_ready_i(mr2), .mem_data_o(md2), .mem_strb_o(ms2),
        .mem_last_o(ml2), .done_o(dn2));

    int n_pass = 0;
    int n_total = 0;
    int n_hold = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    logic s_rr, s_vr, s_mv, s_ml, s_dn;
    logic [1023:0] s_md;
    logic [127:0]  s_ms;

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    function automatic int bb_of(input int k);
        return lanes_of(k) * 8;
    endfunction

    task automatic drive(input int k, input logic rv, input vew_e sw, input logic [15:0] rb,
                         input logic vv, input logic [1023:0] vd, input logic mr);
        case (k)
            0: begin rv0 = rv; sw0 = sw; rb0 = rb; vv0 = vv; vd0 = vd[255:0]; mr0 = mr; end
            1: begin rv1 = rv; sw1 = sw; rb1 = rb; vv1 = vv; vd1 = vd[63:0];  mr1 = mr; end
            default: begin rv2 = rv; sw2 = sw; rb2 = rb; vv2 = vv; vd2 = vd; mr2 = mr; end
        endcase
    endtask

    task automatic sample(input int k);
        case (k)
            0: begin s_rr = rr0; s_vr = vr0; s_mv = mv0; s_ml = ml0; s_dn = dn0;
                     s_md = 1024'(md0); s_ms = 128'(ms0); end
            1: begin s_rr = rr1; s_vr = vr1; s_mv = mv1; s_ml = ml1; s_dn = dn1;
                     s_md = 1024'(md1); s_ms = 128'(ms1); end
            default: begin s_rr = rr2; s_vr = vr2; s_mv = mv2; s_ml = ml2; s_dn = dn2;
                     s_md = md2; s_ms = ms2; end
        endcase
    endtask

    function automatic logic [1023:0] gen_data(input int k, input int beat, input bit ramp);
        logic [1023:0] d = '0;
        for (int j = 0; j < bb_of(k); j++)
            d[j*8 +: 8] = ramp ? 8'(beat * bb_of(k) + j) : 8'($urandom);
        return d;
    endfunction

    // Reference permutation written straight from the element/lane definition.
    function automatic beat_t model(input int k, input vew_e sew, input logic [1023:0] vd, input int rem);
        beat_t r;
        int nl = lanes_of(k);
        int bb = bb_of(k);
        int eb = 1 << int'(sew);
        r.data = '0; r.strb = '0; r.cyc = 0;
        for (int i = 0; i < bb; i++) begin
            int e = i / eb;
            int b = i % eb;
            int src = (e % nl) * 8 + (e / nl) * eb + b;
            r.data[i*8 +: 8] = vd[src*8 +: 8];
            r.strb[i] = (i < rem);
        end
        r.last = (rem <= bb);
        return r;
    endfunction

    // rmode: 0 always ready, 1 random ready, 2 three stalled cycles then ready.
    task automatic run_txn(input int k, input vew_e sew, input int bytes, input int rmode,
                           input bit vrand, input bit ramp);
        int bb = bb_of(k);
        int nbeats = (bytes + bb - 1) / bb;
        int rem = bytes;
        int sent = 0;
        int cyc = 0;
        int stall = 3;
        bit active = 1, pend = 0, done_exp = 0, finished = 0;
        bit mr, vv, exp_vr, p_valid = 0, p_mr = 1;
        logic [1023:0] vd;
        beat_t e, p, o;
        @(negedge clk);
        drive(k, 1'b1, sew, 16'(bytes), 1'b0, '0, 1'b1);
        #1; sample(k);
        n_total++;
        if (s_rr !== 1'b1) $display("FAIL req_ready_accept k=%0d got %b exp 1", k, s_rr); else n_pass++;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0: mr = 1'b1;
                1: mr = ($urandom % 3) != 0;
                default: begin
                    mr = !(pend && stall > 0);
                    if (pend && stall > 0) stall--;
                end
            endcase
            vv = (sent < nbeats) && (!vrand || ($urandom % 4) != 0);
            vd = gen_data(k, sent, ramp);
            drive(k, 1'b0, sew, 16'd0, vv, vd, mr);
            #1; sample(k);
            exp_vr = active && (!pend || mr);
            n_total++;
            if (s_dn !== done_exp) $display("FAIL done k=%0d cyc=%0d got %b exp %b", k, cyc, s_dn, done_exp); else n_pass++;
            n_total++;
            if (s_mv !== pend) $display("FAIL mem_valid k=%0d cyc=%0d got %b exp %b", k, cyc, s_mv, pend); else n_pass++;
            n_total++;
            if (s_vr !== exp_vr) $display("FAIL vrf_ready k=%0d cyc=%0d got %b exp %b", k, cyc, s_vr, exp_vr); else n_pass++;
            if (done_exp) begin
                n_total++;
                if (s_rr !== 1'b1) $display("FAIL idle_after_done k=%0d got %b exp 1", k, s_rr); else n_pass++;
                finished = 1;
            end
            done_exp = 0;
            if (p_valid && !p_mr) begin
                n_hold++;
                n_total++;
                if (s_mv !== 1'b1 || s_md !== p.data || s_ms !== p.strb || s_ml !== p.last)
                    $display("FAIL hold k=%0d cyc=%0d valid=%b strb=%h last=%b exp strb=%h last=%b",
                             k, cyc, s_mv, s_ms, s_ml, p.strb, p.last);
                else n_pass++;
            end
            p_valid = s_mv; p_mr = mr; p.data = s_md; p.strb = s_ms; p.last = s_ml;
            if (pend && mr) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_empty k=%0d got beat exp none", k);
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    n_total++;
                    if (s_md !== e.data) begin
                        for (int j = 0; j < 128; j++)
                            if (s_md[j*8 +: 8] !== e.data[j*8 +: 8]) begin
                                $display("FAIL data k=%0d byte %0d got %h exp %h", k, j, s_md[j*8 +: 8], e.data[j*8 +: 8]);
                                break;
                            end
                    end else n_pass++;
                    n_total++;
                    if (s_ms !== e.strb) $display("FAIL strb k=%0d got %h exp %h", k, s_ms, e.strb); else n_pass++;
                    n_total++;
                    if (s_ml !== e.last) $display("FAIL last k=%0d got %b exp %b", k, s_ml, e.last); else n_pass++;
                    o.data = s_md; o.strb = s_ms; o.last = s_ml; o.cyc = cyc;
                    obs_q.push_back(o);
                    if (e.last) done_exp = 1;
                end
                pend = 0;
            end
            if (vv && exp_vr) begin
                e = model(k, sew, vd, rem);
                exp_q.push_back(e);
                rem = (rem > bb) ? rem - bb : 0;
                sent++;
                pend = 1;
                if (e.last) active = 0;
            end
        end
        n_total++;
        if (!finished) $display("FAIL timeout k=%0d got no done in %0d cycles exp done", k, cyc); else n_pass++;
        @(negedge clk);
        drive(k, 1'b0, sew, 16'd0, 1'b0, '0, 1'b1);
        #1; sample(k);
        n_total++;
        if (s_dn !== 1'b0) $display("FAIL done_single k=%0d got %b exp 0", k, s_dn); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, EW8, 16'd0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sample(k);
            n_total++;
            if (s_mv !== 1'b0 || s_ml !== 1'b0 || s_dn !== 1'b0 || s_ms !== '0 || s_md !== '0)
                $display("FAIL reset_outputs k=%0d got valid=%b last=%b done=%b strb=%h exp all zero",
                         k, s_mv, s_ml, s_dn, s_ms);
            else n_pass++;
            n_total++;
            if (s_rr !== 1'b1 || s_vr !== 1'b0)
                $display("FAIL reset_ready k=%0d got req_ready=%b vrf_ready=%b exp 1/0", k, s_rr, s_vr);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ew8_single();
        obs_q.delete();
        run_txn(0, EW8, 32, 0, 1'b0, 1'b1);
        n_total++;
        if (obs_q.size() != 1) $display("FAIL ew8_beats got %0d exp 1", obs_q.size());
        else begin
            n_pass++;
            n_total++;
            if (obs_q[0].data[39:0] !== 40'h01_18_10_08_00)
                $display("FAIL ew8_bytes got %h exp 0118100800", obs_q[0].data[39:0]); else n_pass++;
            n_total++;
            if (obs_q[0].strb[31:0] !== 32'hFFFF_FFFF || obs_q[0].last !== 1'b1)
                $display("FAIL ew8_strb_last got %h/%b exp ffffffff/1", obs_q[0].strb[31:0], obs_q[0].last);
            else n_pass++;
        end
    endtask

    task automatic test_ew32_two_beats();
        obs_q.delete();
        run_txn(0, EW32, 40, 0, 1'b0, 1'b1);
        n_total++;
        if (obs_q.size() != 2) $display("FAIL ew32_beats got %0d exp 2", obs_q.size());
        else begin
            n_pass++;
            n_total++;
            if (obs_q[0].strb[31:0] !== 32'hFFFF_FFFF || obs_q[0].last !== 1'b0)
                $display("FAIL ew32_beat1 got %h/%b exp ffffffff/0", obs_q[0].strb[31:0], obs_q[0].last);
            else n_pass++;
            n_total++;
            if (obs_q[1].strb[31:0] !== 32'h0000_00FF || obs_q[1].last !== 1'b1)
                $display("FAIL ew32_beat2 got %h/%b exp 000000ff/1", obs_q[1].strb[31:0], obs_q[1].last);
            else n_pass++;
            n_total++;
            if (obs_q[0].data[63:32] !== 32'h0b0a0908 || obs_q[1].data[31:0] !== 32'h23222120)
                $display("FAIL ew32_data got %h %h exp 0b0a0908 23222120", obs_q[0].data[63:32], obs_q[1].data[31:0]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int h0 = n_hold;
        run_txn(0, EW16, 64, 2, 1'b0, 1'b0);
        n_total++;
        if (n_hold - h0 < 3) $display("FAIL stall_cycles got %0d exp >=3", n_hold - h0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        run_txn(0, EW16, 128, 0, 1'b0, 1'b0);
        n_total++;
        if (obs_q.size() != 4) $display("FAIL b2b_beats got %0d exp 4", obs_q.size());
        else begin
            n_pass++;
            for (int i = 1; i < 4; i++) begin
                n_total++;
                if (obs_q[i].cyc != obs_q[0].cyc + i)
                    $display("FAIL b2b_gap beat %0d got cyc %0d exp %0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_zero_bytes(input int k);
        @(negedge clk);
        drive(k, 1'b1, EW32, 16'd0, 1'b0, '0, 1'b1);
        @(negedge clk);
        drive(k, 1'b0, EW32, 16'd0, 1'b0, '0, 1'b1);
        #1; sample(k);
        n_total++;
        if (s_dn !== 1'b1 || s_mv !== 1'b0 || s_rr !== 1'b1)
            $display("FAIL zero_first k=%0d got done=%b valid=%b req_ready=%b exp 1/0/1", k, s_dn, s_mv, s_rr);
        else n_pass++;
        @(negedge clk);
        #1; sample(k);
        n_total++;
        if (s_dn !== 1'b0 || s_mv !== 1'b0 || s_rr !== 1'b1)
            $display("FAIL zero_second k=%0d got done=%b valid=%b req_ready=%b exp 0/0/1", k, s_dn, s_mv, s_rr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(0, 1'b1, EW8, 16'd64, 1'b0, '0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, EW8, 16'd0, 1'b1, gen_data(0, 0, 1'b1), 1'b0);
        @(negedge clk);
        drive(0, 1'b0, EW8, 16'd0, 1'b0, '0, 1'b0);
        #1; sample(0);
        n_total++;
        if (s_mv !== 1'b1) $display("FAIL mid_pending got %b exp 1", s_mv); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        #1; sample(0);
        n_total++;
        if (s_mv !== 1'b0) $display("FAIL mid_discard got %b exp 0", s_mv); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 1'b0, EW8, 16'd0, 1'b0, '0, 1'b1);
        #1; sample(0);
        n_total++;
        if (s_rr !== 1'b1 || s_mv !== 1'b0)
            $display("FAIL mid_release got req_ready=%b valid=%b exp 1/0", s_rr, s_mv);
        else n_pass++;
        exp_q.delete();
        run_txn(0, EW64, 32, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random_lanes();
        for (int k = 0; k < 3; k++)
            for (int t = 0; t < 5; t++)
                run_txn(k, vew_e'($urandom_range(0, 3)), $urandom_range(1, 3 * bb_of(k) + 3), 1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ew8_single();
        test_ew32_two_beats();
        test_backpressure();
        test_back_to_back();
        test_zero_bytes(0);
        test_zero_bytes(1);
        test_reset_mid();
        test_random_lanes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
